fifo_drain_checker: RTL and testbench
=====================================

Name: fifo_drain_checker

Overview:
- Read-side counterpart to the FIFO write driver: drains a `fifo` instance through its read/empty interface and checks each word against a deterministic expected sequence.
- The expected sequence is EXP_BASE + i*EXP_STEP, the same generator as the write-side test array.
- Reports match/error counts, the first mismatch and completion, so FIFO benches are self-checking instead of waveform-inspected.

Parameters:
- DATA_WIDTH, 32, width of FIFO data and expected values.
- TOTAL, 32, number of words to read and check per run (1..2^16-1).
- EXP_BASE, 0, expected value of word 0.
- EXP_STEP, 2, increment between consecutive expected words.
- FILL_MODE, 1, 1 = do not start reading until fifo_full is seen once per run; 0 = read whenever not empty.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse, begins a run (accepted in IDLE or DONE only).
- fifo_empty  input  1  FIFO empty flag.
- fifo_full  input  1  FIFO full flag.
- fifo_data  input  DATA_WIDTH  FIFO output_data.
- fifo_read  output  1  registered read request to the FIFO.
- busy  output  1  high in FILL or DRAIN.
- done  output  1  high in DONE.
- match_count  output  16  words that compared equal this run.
- error_count  output  16  words that compared unequal this run.
- first_err_idx  output  16  index of the first mismatching word; 16'hFFFF if none.
- first_err_data  output  DATA_WIDTH  data received at first_err_idx; 0 if none.

Behaviour:
- Reset: RESET, synchronous, active-high; clock CLK.
  - Reset values: state=IDLE, fifo_read=0, busy=0, done=0, counts=0, first_err_idx=16'hFFFF, first_err_data=0, internal issue/check indices=0, rd_pending=0.
  - Reset asserted mid-run aborts the run immediately on that edge. Nothing is retained; a new start is required.
- FIFO read contract:
  - An effective read occurs in a cycle where fifo_read==1 and fifo_empty==0.
  - The read word is valid on fifo_data exactly one cycle later.
  - fifo_read==1 while fifo_empty==1 is harmless: no read, no count.
- Read driver (registered, same pipeline style as the write driver):
  - issued = number of effective reads so far this run.
  - Each DRAIN cycle: fifo_read <= (issued + eff) < TOTAL and fifo_empty==0, where eff is the current-cycle effective read.
  - issued increments on every effective read, so the block never over-reads past TOTAL.
- Checker:
  - rd_pending <= eff. When rd_pending==1, compare fifo_data with expected[chk_idx], then chk_idx++.
  - Expected value is computed modulo 2^DATA_WIDTH, so wrap-around is legal.
  - Match: match_count++. Mismatch: error_count++; if it is the first mismatch, capture first_err_idx=chk_idx and first_err_data=fifo_data.
  - Counters saturate at 16'hFFFF.
- FSM:
  - IDLE: start -> FILL if FILL_MODE=1, else -> DRAIN. Counters, indices and first_err are cleared on the start edge.
  - FILL: fifo_read=0. fifo_full==1 -> DRAIN. start is ignored.
  - DRAIN: runs the read driver.
    - Empty cycles are bubbles: reading pauses and resumes when not empty; no re-wait for full.
    - Transition to DONE on the edge where the TOTAL-th compare occurs.
    - fifo_read is 0 by then, since the last read was issued one cycle earlier.
  - DONE: done=1 and all results held. start -> same as from IDLE (re-arm, results cleared).
- Latency: first compare is 2 cycles after the first fifo_read assertion with fifo_empty==0. With a never-empty FIFO, DONE is entered TOTAL+1 cycles after the first effective read.
- Boundary: if the FIFO goes empty between the read issue and data return, the in-flight word still completes (already read).

Test Plan:
- FILL_MODE=0, writer streams 0,2,...,62 (TOTAL=32), reads unthrottled -> match_count=32, error_count=0, first_err_idx=FFFF, done=1, exactly 32 effective reads.
- FILL_MODE=1, depth-16 FIFO plus the existing write driver -> no fifo_read until fifo_full first seen; run completes with match_count=32, error_count=0.
- Word 5 corrupted to 0xDEAD -> error_count=1, match_count=31, first_err_idx=5, first_err_data=0xDEAD.
- Empty toggled every 3 cycles during DRAIN -> fifo_read never counts while empty, no over-read beyond 32, results identical to the clean run.
- EXP_BASE=32'hFFFFFFFC, EXP_STEP=2, TOTAL=4, data FFFFFFFC, FFFFFFFE, 0, 2 -> match_count=4 (wrap handled).
- RESET pulsed after 10 compares -> next cycle all outputs at reset values; a new start then completes a full clean 32-word run.

Source files
------------

// File: rtl/fifo_drain_checker.sv
// fifo_drain_checker: drains a FIFO through its read/empty interface and checks every word
// against the sequence EXP_BASE + i*EXP_STEP, reporting match/error counts and the first mismatch.
module fifo_drain_checker #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    TOTAL      = 32,
    parameter logic [DATA_WIDTH-1:0] EXP_BASE   = '0,
    parameter logic [DATA_WIDTH-1:0] EXP_STEP   = DATA_WIDTH'(2),
    parameter bit                    FILL_MODE  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  fifo_empty,
    input  logic                  fifo_full,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           match_count,
    output logic [15:0]           error_count,
    output logic [15:0]           first_err_idx,
    output logic [DATA_WIDTH-1:0] first_err_data
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    localparam logic [16:0] TOT = 17'(TOTAL);

    state_t                state;
    logic [15:0]           issued;
    logic [15:0]           chk_idx;
    logic                  rd_pending;
    logic [DATA_WIDTH-1:0] exp_val;
    logic                  eff;
    logic [16:0]           issued_next;
    logic                  mismatch;
    logic                  last_chk;

    assign eff         = fifo_read && !fifo_empty;
    assign issued_next = {1'b0, issued} + 17'(eff);
    assign mismatch    = fifo_data != exp_val;
    assign last_chk    = chk_idx == 16'(TOTAL - 1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= IDLE;
            fifo_read      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            match_count    <= '0;
            error_count    <= '0;
            first_err_idx  <= 16'hFFFF;
            first_err_data <= '0;
            issued         <= '0;
            chk_idx        <= '0;
            rd_pending     <= 1'b0;
            exp_val        <= EXP_BASE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= FILL_MODE ? FILL : DRAIN;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        fifo_read      <= 1'b0;
                        match_count    <= '0;
                        error_count    <= '0;
                        first_err_idx  <= 16'hFFFF;
                        first_err_data <= '0;
                        issued         <= '0;
                        chk_idx        <= '0;
                        rd_pending     <= 1'b0;
                        exp_val        <= EXP_BASE;
                    end
                end
                FILL: begin
                    if (fifo_full)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Counting the current-cycle read keeps the request from overshooting TOTAL.
                    fifo_read  <= (issued_next < TOT) && !fifo_empty;
                    issued     <= issued_next[15:0];
                    rd_pending <= eff;
                    if (rd_pending) begin
                        chk_idx <= chk_idx + 16'd1;
                        exp_val <= exp_val + EXP_STEP;
                        if (mismatch) begin
                            error_count <= error_count + 16'(error_count != 16'hFFFF);
                            if (error_count == '0) begin
                                first_err_idx  <= chk_idx;
                                first_err_data <= fifo_data;
                            end
                        end else begin
                            match_count <= match_count + 16'(match_count != 16'hFFFF);
                        end
                        if (last_chk) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            fifo_read <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_drain_checker.sv
// tb_fifo_drain_checker: three checker instances (stream, fill-first, wrap) share one queue-based
// FIFO model; table vectors, random runs against a sequence model, and reset/latency sequences.
module tb_fifo_drain_checker;
    logic CLK = 0, RESET = 1, start = 0;
    always #5 CLK = ~CLK;

    logic        fifo_empty = 1, fifo_full = 0;
    logic [31:0] fifo_data = 0;
    int          sel = 0;

    logic [2:0]  rd, bz, dn;
    logic [15:0] mc [3], ec [3], fi [3];
    logic [31:0] fd [3];

    logic        fifo_read, busy, done;
    logic [15:0] match_count, error_count, first_err_idx;
    logic [31:0] first_err_data;

    always_comb begin
        fifo_read      = rd[sel];
        busy           = bz[sel];
        done           = dn[sel];
        match_count    = mc[sel];
        error_count    = ec[sel];
        first_err_idx  = fi[sel];
        first_err_data = fd[sel];
    end

    fifo_drain_checker #(.FILL_MODE(0)) u0 (
        .CLK(CLK), .RESET(RESET), .start(start && sel == 0), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_data(fifo_data), .fifo_read(rd[0]), .busy(bz[0]), .done(dn[0]),
        .match_count(mc[0]), .error_count(ec[0]), .first_err_idx(fi[0]), .first_err_data(fd[0]));
    fifo_drain_checker #(.FILL_MODE(1)) u1 (
        .CLK(CLK), .RESET(RESET), .start(start && sel == 1), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_data(fifo_data), .fifo_read(rd[1]), .busy(bz[1]), .done(dn[1]),
        .match_count(mc[1]), .error_count(ec[1]), .first_err_idx(fi[1]), .first_err_data(fd[1]));
    fifo_drain_checker #(.TOTAL(4), .EXP_BASE(32'hFFFFFFFC), .FILL_MODE(0)) u2 (
        .CLK(CLK), .RESET(RESET), .start(start && sel == 2), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_data(fifo_data), .fifo_read(rd[2]), .busy(bz[2]), .done(dn[2]),
        .match_count(mc[2]), .error_count(ec[2]), .first_err_idx(fi[2]), .first_err_data(fd[2]));

    // Depth-16 FIFO: data appears one cycle after an effective read; flags may be gated empty.
    logic [31:0] q[$], wq[$], words[$];
    bit flush = 0, wr_on = 0, seen_full = 0;
    int rate = 100, gmode = 0, eff_reads = 0, early = 0, cyc = 0;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (flush) begin
            q.delete();
            eff_reads  <= 0;
            early      <= 0;
            seen_full  <= 0;
            fifo_empty <= 1;
            fifo_full  <= 0;
        end else begin
            if (fifo_read && !fifo_empty) begin
                fifo_data <= q.pop_front();
                eff_reads <= eff_reads + 1;
            end
            if (fifo_read && !seen_full && !fifo_full) early <= early + 1;
            if (fifo_full) seen_full <= 1;
            if (wr_on && wq.size() > 0 && q.size() < 16 && $urandom_range(1, 100) <= rate)
                q.push_back(wq.pop_front());
            fifo_full  <= q.size() == 16;
            fifo_empty <= q.size() == 0 || (gmode == 1 && (cyc / 3) % 2 == 1) ||
                          (gmode == 2 && $urandom_range(0, 2) == 0);
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic int tot_of(int s);
        return s == 2 ? 4 : 32;
    endfunction

    function automatic logic [31:0] base_of(int s);
        return s == 2 ? 32'hFFFFFFFC : 32'h0;
    endfunction

    task automatic build(int s, int bad, logic [31:0] bad_val, bit rnd);
        words.delete();
        for (int i = 0; i < tot_of(s) + 4; i++) begin
            logic [31:0] w;
            w = base_of(s) + 32'(i) * 2;
            if (i == bad) w = bad_val;
            if (rnd && $urandom_range(0, 7) == 0) w = w ^ ($urandom() | 32'h1);
            words.push_back(w);
        end
        wq = words;
    endtask

    task automatic setup(int s, int g, int r);
        wr_on = 0;
        flush = 1;
        @(posedge CLK);
        #1 flush = 0;
        sel = s; gmode = g; rate = r; wr_on = 1;
    endtask

    task automatic pulse();
        start = 1;
        @(posedge CLK);
        #1 start = 0;
    endtask

    task automatic wait_done(string nm);
        for (int k = 0; k < 3000 && !done; k++) @(negedge CLK);
        chk({nm, "_done"}, 32'(done), 1);
    endtask

    task automatic check_results(string nm, int s, int m, int e, logic [15:0] idx, logic [31:0] d);
        chk({nm, "_match"}, 32'(match_count), 32'(m));
        chk({nm, "_err"}, 32'(error_count), 32'(e));
        chk({nm, "_fidx"}, 32'(first_err_idx), 32'(idx));
        chk({nm, "_fdata"}, first_err_data, d);
        chk({nm, "_reads"}, 32'(eff_reads), 32'(tot_of(s)));
        chk({nm, "_rd_off"}, 32'(fifo_read), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        if (s == 1) chk({nm, "_early"}, 32'(early), 0);
        repeat (3) @(negedge CLK);
        chk({nm, "_hold"}, {15'd0, done, match_count}, {15'd0, 1'b1, 16'(m)});
    endtask

    task automatic check_reset(string nm);
        chk({nm, "_rd"}, 32'(fifo_read), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_match"}, 32'(match_count), 0);
        chk({nm, "_err"}, 32'(error_count), 0);
        chk({nm, "_fidx"}, 32'(first_err_idx), 32'hFFFF);
        chk({nm, "_fdata"}, first_err_data, 0);
    endtask

    typedef struct {
        int          s;
        int          bad;
        logic [31:0] bad_val;
        int          g;
        int          m;
        int          e;
        logic [15:0] idx;
        logic [31:0] d;
    } vec_t;

    initial begin
        vec_t tv[5];
        int   m, e, kf, k;
        logic [15:0] idx;
        logic [31:0] d;
        tv[0] = '{0, -1, 0, 0, 32, 0, 16'hFFFF, 0};
        tv[1] = '{0, 5, 32'hDEAD, 0, 31, 1, 16'd5, 32'hDEAD};
        tv[2] = '{0, -1, 0, 1, 32, 0, 16'hFFFF, 0};
        tv[3] = '{1, -1, 0, 0, 32, 0, 16'hFFFF, 0};
        tv[4] = '{2, -1, 0, 0, 4, 0, 16'hFFFF, 0};

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_reset("por");
        RESET = 0;

        for (int i = 0; i < 5; i++) begin
            build(tv[i].s, tv[i].bad, tv[i].bad_val, 0);
            setup(tv[i].s, tv[i].g, 100);
            pulse();
            wait_done($sformatf("vec%0d", i));
            check_results($sformatf("vec%0d", i), tv[i].s, tv[i].m, tv[i].e, tv[i].idx, tv[i].d);
        end

        for (int i = 0; i < 8; i++) begin
            int s;
            s = $urandom_range(0, 2);
            build(s, -1, 0, 1);
            m = 0; e = 0; idx = 16'hFFFF; d = 0;
            for (int j = 0; j < tot_of(s); j++) begin
                if (words[j] == base_of(s) + 32'(j) * 2) m++;
                else begin
                    if (e == 0) begin idx = 16'(j); d = words[j]; end
                    e++;
                end
            end
            setup(s, 2, $urandom_range(30, 100));
            pulse();
            wait_done($sformatf("rnd%0d", i));
            check_results($sformatf("rnd%0d", i), s, m, e, idx, d);
        end

        // Never-empty FIFO: first compare 2 cycles after first read, DONE TOTAL+1 cycles after it.
        build(0, -1, 0, 0);
        setup(0, 0, 100);
        repeat (20) @(posedge CLK);
        #1 pulse();
        for (k = 0; k < 50 && !fifo_read; k++) @(negedge CLK);
        chk("lat_read_seen", 32'(fifo_read), 1);
        kf = 0;
        for (k = 0; k < 100 && !done; ) begin
            @(negedge CLK);
            k++;
            if (kf == 0 && match_count != 0) kf = k;
        end
        chk("lat_first_cmp", 32'(kf), 2);
        chk("lat_done", 32'(k), 33);
        chk("lat_reads", 32'(eff_reads), 32);

        // Reset mid-run aborts; a fresh start then runs clean.
        build(0, -1, 0, 0);
        setup(0, 0, 100);
        pulse();
        for (k = 0; k < 500 && match_count < 10; k++) @(negedge CLK);
        chk("mid_reached10", 32'(match_count >= 10), 1);
        RESET = 1;
        @(posedge CLK);
        #1 RESET = 0;
        #1 check_reset("midrst");
        build(0, -1, 0, 0);
        setup(0, 0, 100);
        pulse();
        wait_done("rerun");
        check_results("rerun", 0, 32, 0, 16'hFFFF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
